// File: rtl/inout_bus_ctrl_if.sv
// Core-side signal bundle for inout_bus_ctrl: direction request, transmit data,
// receive data/strobe and status flags. Pin-level tristate buses stay on the module.
interface inout_bus_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             dir_req;
  logic [WIDTH-1:0] tx_data;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             oe;
  logic             busy;
  logic             err;

  modport master (
    output dir_req, tx_data,
    input  rx_data, rx_valid, oe, busy, err
  );

  modport slave (
    input  dir_req, tx_data,
    output rx_data, rx_valid, oe, busy, err
  );
endinterface

// File: rtl/inout_bus_ctrl.sv
// Bidirectional data-bus controller with startup-gated status bus, turnaround gaps
// and a synchronised receive path. Define INOUT_LOOPBACK_EN to add the drive-loopback checker.
module inout_bus_ctrl #(
  parameter int               WIDTH   = 8,
  parameter int               DELAY   = 32,
  parameter int               TURN    = 2,
  parameter logic [WIDTH-1:0] PATTERN = WIDTH'(8'hF0)
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire  [WIDTH-1:0] bus,
  inout  wire  [WIDTH-1:0] stat_io,
  inout_bus_ctrl_if.slave  core
);

  localparam int            CW        = $clog2(DELAY + 2);
  localparam logic [CW-1:0] CNT_DONE  = CW'(DELAY);
  localparam logic [3:0]    TURN_LAST = 4'(TURN - 1);

  localparam logic [2:0] S_STARTUP  = 3'd0;
  localparam logic [2:0] S_RX       = 3'd1;
  localparam logic [2:0] S_TURN_ON  = 3'd2;
  localparam logic [2:0] S_DRIVE    = 3'd3;
  localparam logic [2:0] S_TURN_OFF = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       gap_q, gap_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_first_q;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    case (state_q)
      S_STARTUP: begin
        if (cnt_q != CNT_DONE) cnt_d = cnt_q + 1'b1;
        if (cnt_d == CNT_DONE) state_d = S_RX;
      end
      S_RX: begin
        if (core.dir_req) begin
          state_d = S_TURN_ON;
          gap_d   = '0;
        end
      end
      S_TURN_ON: begin
        if (gap_q == TURN_LAST) state_d = core.dir_req ? S_DRIVE : S_RX;
        else                    gap_d   = gap_q + 1'b1;
      end
      S_DRIVE: begin
        if (!core.dir_req) begin
          state_d = S_TURN_OFF;
          gap_d   = '0;
        end
      end
      S_TURN_OFF: begin
        if (gap_q == TURN_LAST) state_d = S_RX;
        else                    gap_d   = gap_q + 1'b1;
      end
      default: state_d = S_STARTUP;
    endcase
  end

  // Capture is suppressed on the edge that leaves RX, so rx_valid is only ever seen in RX.
  always_comb begin
    tx_d       = tx_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    if (state_q == S_DRIVE || state_d == S_DRIVE) tx_d = core.tx_data;
    if (state_q == S_RX && state_d == S_RX && (rx_first_q || sync2_q != rx_data_q)) begin
      rx_data_d  = sync2_q;
      rx_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (!rst_n) begin
      state_q    <= S_STARTUP;
      cnt_q      <= '0;
      gap_q      <= '0;
      tx_q       <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_first_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      tx_q       <= tx_d;
      sync1_q    <= bus;
      sync2_q    <= sync1_q;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_first_q <= (state_q != S_RX);
    end
  end

  assign core.oe       = (state_q == S_DRIVE);
  assign core.busy     = (state_q == S_STARTUP) || (state_q == S_TURN_ON) || (state_q == S_TURN_OFF);
  assign core.rx_data  = rx_data_q;
  assign core.rx_valid = rx_valid_q;

  assign bus     = core.oe ? tx_q : {WIDTH{1'bz}};
  assign stat_io = (cnt_q == CNT_DONE) ? PATTERN : '0;

`ifdef INOUT_LOOPBACK_EN
  // The synchroniser output lags the driven value by two edges, so compare against tx history.
  logic [WIDTH-1:0] tx_h1_q, tx_h2_q;
  logic [1:0]       drv_cnt_q;
  logic             err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_h1_q   <= '0;
      tx_h2_q   <= '0;
      drv_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tx_h1_q <= tx_q;
      tx_h2_q <= tx_h1_q;
      if (state_q != S_DRIVE)     drv_cnt_q <= '0;
      else if (drv_cnt_q != 2'd2) drv_cnt_q <= drv_cnt_q + 1'b1;
      if (state_q == S_DRIVE && drv_cnt_q == 2'd2 && sync2_q != tx_h2_q) err_q <= 1'b1;
    end
  end

  assign core.err = err_q;
`else
  assign core.err = 1'b0;
`endif

endmodule

// File: tb/tb_inout_bus_ctrl.sv
// Self-checking bench for inout_bus_ctrl: directed scenarios plus randomized traffic
// compared against a spec-level behavioural model.
module tb_inout_bus_ctrl;

  localparam int WIDTH = 8;
  localparam int DELAY = 32;
  localparam int TURN  = 2;

  typedef enum {M_START, M_RX, M_TON, M_DRV, M_TOFF} mode_t;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] ext_val;
  logic             ext_force;
  wire  [WIDTH-1:0] bus;
  wire  [WIDTH-1:0] stat_io;

  int checks = 0;
  int errors = 0;

  inout_bus_ctrl_if #(.WIDTH(WIDTH)) core ();

  inout_bus_ctrl #(.WIDTH(WIDTH), .DELAY(DELAY), .TURN(TURN), .PATTERN(8'hF0)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .stat_io (stat_io),
    .core    (core)
  );

  // External device drives the bus whenever the controller releases it.
  assign bus = (!core.oe || ext_force) ? ext_val : {WIDTH{1'bz}};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: cycles since reset, remaining turnaround cycles, bus sample history.
  mode_t            m_mode;
  int               m_since;
  int               m_turn;
  bit               m_fresh;
  logic [WIDTH-1:0] m_tx, m_rx;
  logic             m_rxv;
  logic [WIDTH-1:0] m_samp [$];

  function automatic logic [WIDTH-1:0] exp_stat();
    return (m_since >= DELAY) ? 8'hF0 : 8'h00;
  endfunction

  function automatic logic exp_oe();
    return m_mode == M_DRV;
  endfunction

  function automatic logic exp_busy();
    return m_mode inside {M_START, M_TON, M_TOFF};
  endfunction

  task automatic model_edge();
    logic [WIDTH-1:0] bus_now, cap;
    mode_t nxt;
    bus_now = (m_mode == M_DRV) ? m_tx : ext_val;
    if (!rst_n) begin
      m_mode = M_START; m_since = 0; m_turn = 0; m_fresh = 1'b0;
      m_tx = '0; m_rx = '0; m_rxv = 1'b0;
      m_samp = '{8'h00, 8'h00};
      return;
    end
    cap   = m_samp[0];
    m_rxv = 1'b0;
    nxt   = m_mode;
    case (m_mode)
      M_START: begin
        m_since++;
        if (m_since >= DELAY) begin nxt = M_RX; m_fresh = 1'b1; end
      end
      M_RX: begin
        if (core.dir_req) begin
          nxt = M_TON; m_turn = TURN;
        end else if (m_fresh || cap != m_rx) begin
          m_rx = cap; m_rxv = 1'b1; m_fresh = 1'b0;
        end
      end
      M_TON: begin
        m_turn--;
        if (m_turn == 0) begin nxt = core.dir_req ? M_DRV : M_RX; m_fresh = 1'b1; end
      end
      M_DRV: if (!core.dir_req) begin nxt = M_TOFF; m_turn = TURN; end
      M_TOFF: begin
        m_turn--;
        if (m_turn == 0) begin nxt = M_RX; m_fresh = 1'b1; end
      end
      default: nxt = M_START;
    endcase
    if (nxt == M_DRV || m_mode == M_DRV) m_tx = core.tx_data;
    m_samp.push_back(bus_now);
    void'(m_samp.pop_front());
    m_mode = nxt;
  endtask

  // Inputs are applied at the falling edge; the model predicts the next rising edge.
  task automatic tick();
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; core.dir_req = 1'b0; core.tx_data = '0; ext_val = '0; ext_force = 1'b0;
    tick(); tick();
    checks++; if (core.oe !== 1'b0) begin errors++; $display("FAIL reset_oe got=%0b exp=0", core.oe); end
    checks++; if (core.busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%0b exp=1", core.busy); end
    checks++; if (stat_io !== 8'h00) begin errors++; $display("FAIL reset_stat got=%h exp=00", stat_io); end
    checks++; if (core.rx_data !== 8'h00 || core.rx_valid !== 1'b0) begin
      errors++; $display("FAIL reset_rx got=%h/%0b exp=00/0", core.rx_data, core.rx_valid);
    end
    checks++; if (core.err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b exp=0", core.err); end
  endtask

  task automatic test_startup();
    logic [WIDTH-1:0] want;
    rst_n = 1'b1;
    for (int i = 1; i <= DELAY + 320; i++) begin
      tick();
      want = (i >= DELAY) ? 8'hF0 : 8'h00;
      checks++; if (stat_io !== want) begin errors++; $display("FAIL startup_stat edge=%0d got=%h exp=%h", i, stat_io, want); end
      checks++; if (core.busy !== (i < DELAY)) begin errors++; $display("FAIL startup_busy edge=%0d got=%0b exp=%0b", i, core.busy, i < DELAY); end
      checks++; if (core.rx_valid !== m_rxv) begin errors++; $display("FAIL startup_rxv edge=%0d got=%0b exp=%0b", i, core.rx_valid, m_rxv); end
    end
  endtask

  task automatic test_receive();
    ext_val = 8'hA5;
    tick(); tick();
    checks++; if (core.rx_data !== 8'h00) begin errors++; $display("FAIL rx_early got=%h exp=00", core.rx_data); end
    tick();
    checks++; if (core.rx_data !== 8'hA5 || core.rx_valid !== 1'b1) begin
      errors++; $display("FAIL rx_capture got=%h/%0b exp=a5/1", core.rx_data, core.rx_valid);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (core.rx_valid !== 1'b0 || core.rx_data !== 8'hA5) begin
        errors++; $display("FAIL rx_hold cyc=%0d got=%h/%0b exp=a5/0", i, core.rx_data, core.rx_valid);
      end
    end
  endtask

  task automatic test_drive();
    core.dir_req = 1'b1; core.tx_data = 8'h3C;
    for (int i = 0; i < TURN; i++) begin
      tick();
      checks++; if (core.oe !== 1'b0 || core.busy !== 1'b1) begin
        errors++; $display("FAIL turn_on cyc=%0d got oe=%0b busy=%0b exp oe=0 busy=1", i, core.oe, core.busy);
      end
    end
    tick();
    checks++; if (core.oe !== 1'b1 || core.busy !== 1'b0) begin
      errors++; $display("FAIL drive_enter got oe=%0b busy=%0b exp oe=1 busy=0", core.oe, core.busy);
    end
    checks++; if (bus !== 8'h3C) begin errors++; $display("FAIL drive_bus got=%h exp=3c", bus); end
    core.tx_data = 8'hC3;
    tick();
    checks++; if (bus !== 8'hC3) begin errors++; $display("FAIL drive_follow got=%h exp=c3", bus); end
  endtask

  task automatic test_turn_off();
    core.dir_req = 1'b0; ext_val = 8'h5A;
    for (int i = 0; i < TURN; i++) begin
      tick();
      checks++; if (core.oe !== 1'b0 || core.busy !== 1'b1 || core.rx_valid !== 1'b0) begin
        errors++; $display("FAIL turn_off cyc=%0d got oe=%0b busy=%0b rxv=%0b exp 0/1/0", i, core.oe, core.busy, core.rx_valid);
      end
    end
    tick();
    checks++; if (core.busy !== 1'b0) begin errors++; $display("FAIL turn_off_rx got busy=%0b exp=0", core.busy); end
    tick();
    checks++; if (core.rx_valid !== 1'b1 || core.rx_data !== 8'h5A) begin
      errors++; $display("FAIL turn_off_capture got=%h/%0b exp=5a/1", core.rx_data, core.rx_valid);
    end
    tick();
    checks++; if (core.rx_valid !== 1'b0) begin errors++; $display("FAIL turn_off_single got=%0b exp=0", core.rx_valid); end
  endtask

  task automatic test_mid_reset();
    logic [WIDTH-1:0] want;
    core.dir_req = 1'b1; core.tx_data = 8'h77;
    for (int i = 0; i < TURN + 2; i++) tick();
    checks++; if (core.oe !== 1'b1) begin errors++; $display("FAIL mid_reset_pre got oe=%0b exp=1", core.oe); end
    rst_n = 1'b0;
    tick();
    checks++; if (core.oe !== 1'b0 || stat_io !== 8'h00 || core.busy !== 1'b1) begin
      errors++; $display("FAIL mid_reset got oe=%0b stat=%h busy=%0b exp 0/00/1", core.oe, stat_io, core.busy);
    end
    rst_n = 1'b1; core.dir_req = 1'b0;
    for (int i = 1; i <= DELAY + 4; i++) begin
      tick();
      want = (i >= DELAY) ? 8'hF0 : 8'h00;
      checks++; if (stat_io !== want) begin errors++; $display("FAIL restart_stat edge=%0d got=%h exp=%h", i, stat_io, want); end
    end
  endtask

  task automatic test_loopback();
    bit seen;
    logic exp_err;
`ifdef INOUT_LOOPBACK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    ext_force = 1'b1; ext_val = 8'h01; core.tx_data = 8'h00; core.dir_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < TURN + 8 && !seen; i++) begin
      tick();
      if (core.err === 1'b1) seen = 1'b1;
    end
    checks++; if (core.err !== exp_err) begin errors++; $display("FAIL loopback_err got=%0b exp=%0b", core.err, exp_err); end
    core.dir_req = 1'b0;
    for (int i = 0; i < TURN + 4; i++) tick();
    checks++; if (core.err !== exp_err) begin errors++; $display("FAIL loopback_sticky got=%0b exp=%0b", core.err, exp_err); end
    ext_force = 1'b0; rst_n = 1'b0;
    tick();
    checks++; if (core.err !== 1'b0) begin errors++; $display("FAIL loopback_clear got=%0b exp=0", core.err); end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(7) == 0) core.dir_req = ~core.dir_req;
      core.tx_data = WIDTH'($urandom);
      if ($urandom_range(3) == 0) ext_val = WIDTH'($urandom);
      rst_n = ($urandom_range(499) != 0);
      tick();
      checks++; if (core.oe !== exp_oe() || core.busy !== exp_busy()) begin
        errors++; $display("FAIL rand_ctrl n=%0d got oe=%0b busy=%0b exp oe=%0b busy=%0b", n, core.oe, core.busy, exp_oe(), exp_busy());
      end
      checks++; if (stat_io !== exp_stat()) begin errors++; $display("FAIL rand_stat n=%0d got=%h exp=%h", n, stat_io, exp_stat()); end
      checks++; if (core.rx_data !== m_rx || core.rx_valid !== m_rxv) begin
        errors++; $display("FAIL rand_rx n=%0d got=%h/%0b exp=%h/%0b", n, core.rx_data, core.rx_valid, m_rx, m_rxv);
      end
      checks++; if (core.err !== 1'b0) begin errors++; $display("FAIL rand_err n=%0d got=%0b exp=0", n, core.err); end
      if (exp_oe()) begin
        checks++; if (bus !== m_tx) begin errors++; $display("FAIL rand_bus n=%0d got=%h exp=%h", n, bus, m_tx); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_receive();
    test_drive();
    test_turn_off();
    test_mid_reset();
    test_loopback();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
